// File: rtl/window_fetch_ctrl_pkg.sv
// rtl/window_fetch_ctrl_pkg.sv - shared types and constants for the window fetch sequencer
package window_fetch_ctrl_pkg;

  localparam int WIN          = 16;
  localparam int STORE_COLS   = 80;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_SWEEP,
    ST_SHIFT,
    ST_DONE
  } fetch_state_t;

  // Travels alongside each read so the store strobes line up with returning data
  typedef struct packed {
    logic       valid;
    logic       new_row;
    logic [6:0] row;
    logic [6:0] col;
  } pipe_tag_t;

  function automatic logic [6:0] word_col(input logic [4:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/window_fetch_ctrl_rd_lat_pipe.sv
// rtl/window_fetch_ctrl_rd_lat_pipe.sv - read-latency tag delay line with asynchronous clear
module window_fetch_ctrl_rd_lat_pipe
  import window_fetch_ctrl_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  pipe_tag_t tag_in,
  output pipe_tag_t tag_out,
  output logic      pending
);

  pipe_tag_t stage_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

  // Any valid stage means a load has yet to reach (or is reaching) the store
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      pending = pending | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/window_fetch_ctrl.sv
// rtl/window_fetch_ctrl.sv - read sequencer feeding the 16-row sliding window store
module window_fetch_ctrl
  import window_fetch_ctrl_pkg::*;
#(
  parameter int IMG_W     = 80,
  parameter int IMG_H     = 80,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              load,
  output logic              new_row,
  output logic [6:0]        row,
  output logic [6:0]        col,
  output logic [6:0]        window_offset,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done
);

  localparam int         IMG_COLS      = (IMG_W < STORE_COLS) ? IMG_W : STORE_COLS;
  localparam int         WPR           = IMG_COLS / PIX_PER_WORD;
  localparam logic [4:0] LAST_WORD     = 5'(WPR - 1);
  localparam logic [6:0] LAST_FILL_ROW = 7'(WIN - 1);
  localparam logic [6:0] LAST_OFFSET   = 7'(IMG_COLS - WIN);
  localparam logic [6:0] ROWS_TOTAL    = 7'(IMG_H);

  fetch_state_t state_q, state_d;
  logic [4:0]   word_idx_q;
  logic [6:0]   img_row_q;
  logic [6:0]   rows_loaded_q;
  logic [6:0]   window_offset_q;
  logic [6:0]   rd_row;
  pipe_tag_t    tag_in, tag_out;
  logic         pipe_pending;
  logic         last_word;
  logic         handshake;
  logic         sweep_last;

  assign last_word  = (word_idx_q == LAST_WORD);
  assign handshake  = win_valid & win_ready;
  assign sweep_last = (window_offset_q >= LAST_OFFSET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    rd_row  = '0;
    tag_in  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FILL;
      end
      ST_FILL: begin
        mem_rd         = 1'b1;
        rd_row         = img_row_q;
        tag_in.valid   = 1'b1;
        tag_in.row     = img_row_q;
        tag_in.col     = word_col(word_idx_q);
        if (last_word && img_row_q == LAST_FILL_ROW) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_pending) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (handshake && sweep_last) begin
          state_d = (rows_loaded_q < ROWS_TOTAL) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        // Word 0 of each new row tells the store to shift rows up first
        mem_rd         = 1'b1;
        rd_row         = rows_loaded_q;
        tag_in.valid   = 1'b1;
        tag_in.new_row = (word_idx_q == 5'd0);
        tag_in.row     = LAST_FILL_ROW;
        tag_in.col     = word_col(word_idx_q);
        if (last_word) state_d = ST_DRAIN;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    if (mem_rd) begin
      mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_row) * ADDR_W'(WPR) + ADDR_W'(word_idx_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx_q      <= '0;
      img_row_q       <= '0;
      rows_loaded_q   <= '0;
      window_offset_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            word_idx_q      <= '0;
            img_row_q       <= '0;
            rows_loaded_q   <= '0;
            window_offset_q <= '0;
          end
        end
        ST_FILL: begin
          if (last_word) begin
            word_idx_q <= '0;
            if (img_row_q == LAST_FILL_ROW) begin
              rows_loaded_q <= 7'(WIN);
            end else begin
              img_row_q <= img_row_q + 7'd1;
            end
          end else begin
            word_idx_q <= word_idx_q + 5'd1;
          end
        end
        ST_DRAIN: begin
          if (!pipe_pending) window_offset_q <= '0;
        end
        ST_SWEEP: begin
          if (handshake && !sweep_last) window_offset_q <= window_offset_q + 7'd1;
        end
        ST_SHIFT: begin
          if (last_word) begin
            word_idx_q <= '0;
            if (rows_loaded_q != ROWS_TOTAL) rows_loaded_q <= rows_loaded_q + 7'd1;
          end else begin
            word_idx_q <= word_idx_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  window_fetch_ctrl_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .pending (pipe_pending)
  );

  assign load          = tag_out.valid;
  assign new_row       = tag_out.new_row;
  assign row           = tag_out.row;
  assign col           = tag_out.col;
  assign window_offset = window_offset_q;
  assign win_valid     = (state_q == ST_SWEEP);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// tb/tb_window_fetch_ctrl.sv - self-checking bench for window_fetch_ctrl
module tb_window_fetch_ctrl;

  localparam int IMG_W  = 80;
  localparam int IMG_H  = 18;
  localparam int RD_LAT = 2;
  localparam int WPR    = IMG_W / 4;
  localparam int WIN    = 16;
  localparam int NPOS   = IMG_W - WIN + 1;
  localparam int NFILL  = WIN * WPR;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, win_ready = 1'b0;

  logic        mem_rd, load, new_row, win_valid, busy, done;
  logic [15:0] mem_addr;
  logic [6:0]  row, col, window_offset;
  logic        mem_rd_s, load_s, new_row_s, win_valid_s, busy_s, done_s;
  logic [15:0] mem_addr_s;
  logic [6:0]  row_s, col_s, window_offset_s;
  logic [42:0] outs_all;

  always #5 clk = ~clk;

  window_fetch_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(16), .BASE_ADDR(0), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr), .load(load),
    .new_row(new_row), .row(row), .col(col), .window_offset(window_offset), .win_valid(win_valid),
    .win_ready(win_ready), .busy(busy), .done(done));

  window_fetch_ctrl #(.IMG_W(IMG_W), .IMG_H(WIN), .ADDR_W(16), .BASE_ADDR(0), .RD_LAT(RD_LAT)) dut16 (
    .clk(clk), .rst(rst), .start(start), .mem_rd(mem_rd_s), .mem_addr(mem_addr_s), .load(load_s),
    .new_row(new_row_s), .row(row_s), .col(col_s), .window_offset(window_offset_s), .win_valid(win_valid_s),
    .win_ready(win_ready), .busy(busy_s), .done(done_s));

  assign outs_all = {mem_rd, mem_addr, load, new_row, row, col, window_offset, win_valid, busy, done};

  typedef struct {int cyc; int addr; int hs_before;} rd_t;
  typedef struct {int cyc; int row; int col; bit nr;} ld_t;

  rd_t rd_q[$];
  ld_t ld_q[$];
  int  hs_off[$];
  int  hs_cyc[$];
  int  cyc, done_cnt, viol_hold, viol_pend, first_valid_cyc;
  int  n_rd16, n_hs16, done16;
  bit  prev_stall;
  int  prev_off;
  int  n_vec, n_err;

  always @(negedge clk) begin
    cyc++;
    if (mem_rd) rd_q.push_back('{cyc: cyc, addr: int'(mem_addr), hs_before: hs_off.size()});
    if (load) ld_q.push_back('{cyc: cyc, row: int'(row), col: int'(col), nr: new_row});
    if (win_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (load || rd_q.size() != ld_q.size()) viol_pend++;
    end
    if (prev_stall && (!win_valid || int'(window_offset) != prev_off)) viol_hold++;
    prev_stall = win_valid && !win_ready;
    prev_off   = int'(window_offset);
    if (win_valid && win_ready) begin
      hs_off.push_back(int'(window_offset));
      hs_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (mem_rd_s) n_rd16++;
    if (win_valid_s && win_ready) n_hs16++;
    if (done_s) done16++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    rd_q.delete(); ld_q.delete(); hs_off.delete(); hs_cyc.delete();
    done_cnt = 0; viol_hold = 0; viol_pend = 0; first_valid_cyc = -1;
    n_rd16 = 0; n_hs16 = 0; done16 = 0; prev_stall = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_reset;
    bit found;
    @(negedge clk);
    n_vec++; if (outs_all !== '0) begin n_err++; $display("FAIL por_outputs: got %h expected 0", outs_all); end
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && mem_addr === 16'd99) found = 1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL reach_read99: got %0d expected 1", found); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (outs_all !== '0) begin n_err++; $display("FAIL async_reset_outputs: got %h expected 0", outs_all); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    clear_mon();
    repeat (10) tick();
    n_vec++; if (ld_q.size() != 0) begin n_err++; $display("FAIL load_after_reset: got %0d expected 0", ld_q.size()); end
    n_vec++; if (rd_q.size() != 0) begin n_err++; $display("FAIL read_after_reset: got %0d expected 0", rd_q.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_reset: got %0d expected 0", busy); end
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 10 && rd_q.size() == 0; c++) tick();
    n_vec++;
    if (rd_q.size() == 0) begin n_err++; $display("FAIL restart_read: got none expected addr 0"); end
    else if (rd_q[0].addr != 0) begin n_err++; $display("FAIL restart_addr: got %0d expected 0", rd_q[0].addr); end
    do_reset();
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0, 2: random ready
  task automatic test_full_frame(input int mode, input bit poke_start);
    int  exp_addr[$], exp_row[$], exp_col[$], exp_off[$];
    bit  exp_nr[$];
    int  n_cyc, idx;
    bit  poked;
    for (int r = 0; r < WIN; r++)
      for (int w = 0; w < WPR; w++) begin
        exp_addr.push_back(r * WPR + w); exp_row.push_back(r); exp_col.push_back(4 * w); exp_nr.push_back(1'b0);
      end
    for (int r = WIN; r < IMG_H; r++)
      for (int w = 0; w < WPR; w++) begin
        exp_addr.push_back(r * WPR + w); exp_row.push_back(WIN - 1); exp_col.push_back(4 * w); exp_nr.push_back(w == 0);
      end
    for (int s = 0; s <= IMG_H - WIN; s++)
      for (int o = 0; o < NPOS; o++) exp_off.push_back(o);

    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n_cyc = 0; poked = 0;
    while (done_cnt == 0 && n_cyc < 6000) begin
      case (mode)
        0: win_ready = 1'b1;
        1: win_ready = (n_cyc % 3 == 0);
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
      start = 1'b0;
      if (poke_start && win_valid && !poked) begin start = 1'b1; poked = 1; end
      tick();
      n_cyc++;
    end
    start = 1'b0; win_ready = 1'b0;
    n_vec++; if (done_cnt == 0) begin n_err++; $display("FAIL frame_timeout mode%0d: got no done expected done", mode); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done mode%0d: got %0d expected 0", mode, busy); end
    repeat (5) tick();
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL done_pulses mode%0d: got %0d expected 1", mode, done_cnt); end
    n_vec++; if (rd_q.size() != exp_addr.size()) begin n_err++; $display("FAIL read_count mode%0d: got %0d expected %0d", mode, rd_q.size(), exp_addr.size()); end
    n_vec++; if (ld_q.size() != exp_addr.size()) begin n_err++; $display("FAIL load_count mode%0d: got %0d expected %0d", mode, ld_q.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < rd_q.size(); i++) begin
      n_vec++; if (rd_q[i].addr != exp_addr[i]) begin n_err++; $display("FAIL read_addr[%0d]: got %0d expected %0d", i, rd_q[i].addr, exp_addr[i]); end
      if (i > 0 && !(i >= NFILL && i % WPR == 0)) begin
        n_vec++; if (rd_q[i].cyc != rd_q[i-1].cyc + 1) begin n_err++; $display("FAIL read_gap[%0d]: got cycle %0d expected %0d", i, rd_q[i].cyc, rd_q[i-1].cyc + 1); end
      end
      if (i < ld_q.size()) begin
        n_vec++; if (ld_q[i].cyc != rd_q[i].cyc + RD_LAT) begin n_err++; $display("FAIL load_latency[%0d]: got cycle %0d expected %0d", i, ld_q[i].cyc, rd_q[i].cyc + RD_LAT); end
        n_vec++;
        if (ld_q[i].row != exp_row[i] || ld_q[i].col != exp_col[i] || ld_q[i].nr != exp_nr[i]) begin
          n_err++;
          $display("FAIL load_tag[%0d]: got row %0d col %0d nr %0d expected row %0d col %0d nr %0d",
                   i, ld_q[i].row, ld_q[i].col, ld_q[i].nr, exp_row[i], exp_col[i], exp_nr[i]);
        end
      end
    end
    for (int k = 0; k < IMG_H - WIN; k++) begin
      idx = NFILL + k * WPR;
      if (idx < rd_q.size()) begin
        n_vec++; if (rd_q[idx].hs_before != NPOS * (k + 1)) begin n_err++; $display("FAIL shift_after_sweep[%0d]: got %0d expected %0d", k, rd_q[idx].hs_before, NPOS * (k + 1)); end
      end
    end
    n_vec++; if (hs_off.size() != exp_off.size()) begin n_err++; $display("FAIL handshakes mode%0d: got %0d expected %0d", mode, hs_off.size(), exp_off.size()); end
    for (int i = 0; i < exp_off.size() && i < hs_off.size(); i++) begin
      n_vec++; if (hs_off[i] != exp_off[i]) begin n_err++; $display("FAIL offset[%0d]: got %0d expected %0d", i, hs_off[i], exp_off[i]); end
    end
    if (ld_q.size() >= NFILL) begin
      n_vec++; if (first_valid_cyc <= ld_q[NFILL-1].cyc) begin n_err++; $display("FAIL valid_before_fill: got cycle %0d expected > %0d", first_valid_cyc, ld_q[NFILL-1].cyc); end
    end
    n_vec++; if (viol_pend != 0) begin n_err++; $display("FAIL valid_with_pending mode%0d: got %0d expected 0", mode, viol_pend); end
    n_vec++; if (viol_hold != 0) begin n_err++; $display("FAIL stall_hold mode%0d: got %0d expected 0", mode, viol_hold); end
    if (mode == 0 && hs_cyc.size() >= NPOS) begin
      for (int i = 1; i < NPOS; i++) begin
        n_vec++; if (hs_cyc[i] != hs_cyc[0] + i) begin n_err++; $display("FAIL sweep_consecutive[%0d]: got %0d expected %0d", i, hs_cyc[i], hs_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int n_cyc;
    do_reset();
    start = 1'b1;
    n_cyc = 0;
    while (done_cnt == 0 && n_cyc < 6000) begin
      win_ready = 1'($urandom_range(0, 1));
      tick();
      n_cyc++;
    end
    n_vec++; if (rd_q.size() != NFILL + (IMG_H - WIN) * WPR) begin n_err++; $display("FAIL b2b_reads: got %0d expected %0d", rd_q.size(), NFILL + (IMG_H - WIN) * WPR); end
    rd_q.delete();
    repeat (4) tick();
    n_vec++;
    if (rd_q.size() == 0) begin n_err++; $display("FAIL b2b_restart: got no read expected addr 0"); end
    else if (rd_q[0].addr != 0) begin n_err++; $display("FAIL b2b_restart_addr: got %0d expected 0", rd_q[0].addr); end
    start = 1'b0;
    do_reset();
  endtask

  task automatic test_small_frame;
    int n_cyc;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n_cyc = 0;
    while (done16 == 0 && n_cyc < 4000) begin
      win_ready = 1'($urandom_range(0, 1));
      tick();
      n_cyc++;
    end
    win_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL h16_busy: got %0d expected 0", busy_s); end
    n_vec++; if (done16 != 1) begin n_err++; $display("FAIL h16_done: got %0d expected 1", done16); end
    n_vec++; if (n_rd16 != NFILL) begin n_err++; $display("FAIL h16_reads: got %0d expected %0d", n_rd16, NFILL); end
    n_vec++; if (n_hs16 != NPOS) begin n_err++; $display("FAIL h16_windows: got %0d expected %0d", n_hs16, NPOS); end
    do_reset();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    clear_mon();
    test_reset();
    test_full_frame(0, 1'b0);
    test_full_frame(1, 1'b0);
    test_full_frame(2, 1'b1);
    test_back_to_back();
    test_small_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
